// File: rtl/rocc_mem_pkg.sv
// Shared constants for the accelerator memory-port arbiter: HellaCache command/size codes
// and default port widths.
package rocc_mem_pkg;

  localparam logic [4:0] M_XRD = 5'h0;
  localparam logic [4:0] M_XWR = 5'h1;
  localparam logic [2:0] MT_D  = 3'h3;

  localparam int unsigned DEF_TAG_W  = 10;
  localparam int unsigned DEF_ADDR_W = 40;
  localparam int unsigned DEF_DATA_W = 64;

  // Wide enough for MAX_OUT up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      // j is a constant per unrolled iteration, so the match is a plain compare.
      for (int unsigned j = 0; j < N; j++) begin
        if (!valid && req[j] && ((32'(ptr) + k) % N) == j) begin
          valid     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/rocc_mem_arbiter.sv
// Shares one accelerator memory port among NUM_REQ requesters with round-robin grant,
// per-requester in-flight credit, and tag-indexed response steering.
module rocc_mem_arbiter
  import rocc_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned SRC_TAG_W = TAG_W - IDX_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_OUT   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*SRC_TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*5-1:0]          req_cmd,
  input  logic [NUM_REQ*3-1:0]          req_typ,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [TAG_W-1:0]              mem_req_tag,
  output logic [4:0]                    mem_req_cmd,
  output logic [2:0]                    mem_req_typ,
  output logic [DATA_W-1:0]             mem_req_data,
  output logic                          mem_req_phys,
  input  logic                          mem_resp_valid,
  input  logic [TAG_W-1:0]              mem_resp_tag,
  input  logic [DATA_W-1:0]             mem_resp_data,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [SRC_TAG_W-1:0]          resp_tag,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          busy,
  output logic                          err
);

  logic [CNT_W-1:0]     out_cnt_q [NUM_REQ];
  logic [CNT_W-1:0]     out_cnt_d [NUM_REQ];
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   eligible, grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 fire;
  logic [IDX_W-1:0]     resp_idx;
  logic [SRC_TAG_W-1:0] src_tag;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (out_cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (mem_req_valid)
  );

  assign fire         = mem_req_valid && mem_req_ready;
  assign req_ready    = grant & {NUM_REQ{mem_req_ready}};
  assign mem_req_phys = 1'b1;
  assign mem_req_tag  = {grant_idx, src_tag};

  // One-hot grant, so an OR of masked fields is the mux.
  always_comb begin
    mem_req_addr = '0;
    src_tag      = '0;
    mem_req_cmd  = '0;
    mem_req_typ  = '0;
    mem_req_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_req_addr = mem_req_addr | req_addr[i*ADDR_W +: ADDR_W];
        src_tag      = src_tag | req_tag[i*SRC_TAG_W +: SRC_TAG_W];
        mem_req_cmd  = mem_req_cmd | req_cmd[i*5 +: 5];
        mem_req_typ  = mem_req_typ | req_typ[i*3 +: 3];
        mem_req_data = mem_req_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign resp_idx  = mem_resp_tag[TAG_W-1 -: IDX_W];
  assign resp_tag  = mem_resp_tag[SRC_TAG_W-1:0];
  assign resp_data = mem_resp_data;

  always_comb begin
    err_d    = err_q;
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    if (mem_resp_valid && 32'(resp_idx) >= NUM_REQ) begin
      err_d = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = mem_resp_valid && (resp_idx == IDX_W'(i));
      out_cnt_d[i]  = out_cnt_q[i];
      // A response with no credit outstanding is forwarded but never drives the count below 0.
      if (resp_valid[i] && out_cnt_q[i] == '0) begin
        err_d = 1'b1;
      end
      if (fire && grant[i] && !(resp_valid[i] && out_cnt_q[i] != '0)) begin
        out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      end else if (!(fire && grant[i]) && resp_valid[i] && out_cnt_q[i] != '0) begin
        out_cnt_d[i] = out_cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = |req_valid;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      busy = busy || (out_cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// Bench for rocc_mem_arbiter: directed scenarios plus random traffic against a model that
// tracks outstanding tags in a scoreboard queue.
module tb_rocc_mem_arbiter;
  import rocc_mem_pkg::*;

  localparam int N    = 2;
  localparam int TW   = 10;
  localparam int IW   = 2;
  localparam int STW  = 8;
  localparam int AW   = 40;
  localparam int DW   = 64;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*STW-1:0] req_tag;
  logic [N*5-1:0]  req_cmd;
  logic [N*3-1:0]  req_typ;
  logic [N*DW-1:0] req_data;
  logic            mem_req_valid, mem_req_ready, mem_req_phys;
  logic [AW-1:0]   mem_req_addr;
  logic [TW-1:0]   mem_req_tag;
  logic [4:0]      mem_req_cmd;
  logic [2:0]      mem_req_typ;
  logic [DW-1:0]   mem_req_data;
  logic            mem_resp_valid;
  logic [TW-1:0]   mem_resp_tag;
  logic [DW-1:0]   mem_resp_data;
  logic [N-1:0]    resp_valid;
  logic [STW-1:0]  resp_tag;
  logic [DW-1:0]   resp_data;
  logic            busy, err;

  always #5 clk = ~clk;

  rocc_mem_arbiter #(
    .NUM_REQ   (N),
    .TAG_W     (TW),
    .IDX_W     (IW),
    .SRC_TAG_W (STW),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_OUT   (MAXO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_tag        (req_tag),
    .req_cmd        (req_cmd),
    .req_typ        (req_typ),
    .req_data       (req_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_tag    (mem_req_tag),
    .mem_req_cmd    (mem_req_cmd),
    .mem_req_typ    (mem_req_typ),
    .mem_req_data   (mem_req_data),
    .mem_req_phys   (mem_req_phys),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_tag   (mem_resp_tag),
    .mem_resp_data  (mem_resp_data),
    .resp_valid     (resp_valid),
    .resp_tag       (resp_tag),
    .resp_data      (resp_data),
    .busy           (busy),
    .err            (err)
  );

  logic [AW-1:0]  a_addr [N];
  logic [STW-1:0] a_tag  [N];
  logic [4:0]     a_cmd  [N];
  logic [2:0]     a_typ  [N];
  logic [DW-1:0]  a_data [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW]   = a_addr[g];
    assign req_tag[g*STW +: STW]  = a_tag[g];
    assign req_cmd[g*5 +: 5]      = a_cmd[g];
    assign req_typ[g*3 +: 3]      = a_typ[g];
    assign req_data[g*DW +: DW]   = a_data[g];
  end

  // Reference model: full tags of every request in flight, the rotating priority, sticky error.
  logic [TW-1:0] pend [$];
  int            rr;
  bit            err_m;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] obs_ready, obs_rv;
  logic [TW-1:0] obs_tag;
  logic [STW-1:0] obs_rtag;
  logic obs_err, obs_busy, obs_mvalid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int cnt_of(input int r);
    int c = 0;
    foreach (pend[j]) if (int'(pend[j][TW-1 -: IW]) == r) c++;
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_tag = '0;
    mem_resp_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    pend.delete();
    rr = 0;
    err_m = 1'b0;
  endtask

  task automatic step(input logic [N-1:0] v, input logic rdy, input logic rv,
                      input logic [TW-1:0] rtag);
    int g, i, ridx;
    logic [N-1:0] er, erv;
    req_valid = v;
    mem_req_ready = rdy;
    mem_resp_valid = rv;
    mem_resp_tag = rtag;
    mem_resp_data = {$urandom, $urandom};
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
      if (g < 0 && v[i] && cnt_of(i) < MAXO) g = i;
    end
    er = (g >= 0 && rdy) ? N'(1 << g) : '0;
    ridx = int'(rtag[TW-1 -: IW]);
    erv = (rv && ridx < N) ? N'(1 << ridx) : '0;
    check("mem_req_valid", mem_req_valid, g >= 0);
    if (g >= 0) begin
      check("mem_req_tag", mem_req_tag, {IW'(g), a_tag[g]});
      check("mem_req_addr", mem_req_addr, a_addr[g]);
      check("mem_req_cmd", mem_req_cmd, a_cmd[g]);
      check("mem_req_typ", mem_req_typ, a_typ[g]);
      check("mem_req_data", mem_req_data, a_data[g]);
    end
    check("req_ready", req_ready, er);
    check("mem_req_phys", mem_req_phys, 1'b1);
    check("resp_valid", resp_valid, erv);
    check("resp_tag", resp_tag, rtag[STW-1:0]);
    check("resp_data", resp_data, mem_resp_data);
    check("busy", busy, (v != '0) || (pend.size() > 0));
    check("err", err, err_m);
    obs_ready = req_ready;
    obs_rv = resp_valid;
    obs_tag = mem_req_tag;
    obs_rtag = resp_tag;
    obs_err = err;
    obs_busy = busy;
    obs_mvalid = mem_req_valid;
    if (rv) begin
      if (ridx >= N || cnt_of(ridx) == 0) begin
        err_m = 1'b1;
      end else begin
        for (int j = 0; j < pend.size(); j++) begin
          if (int'(pend[j][TW-1 -: IW]) == ridx) begin
            pend.delete(j);
            break;
          end
        end
      end
    end
    if (g >= 0 && rdy) begin
      pend.push_back({IW'(g), a_tag[g]});
      rr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      a_addr[i] = {8'($urandom), $urandom};
      a_tag[i]  = STW'($urandom);
      a_cmd[i]  = ($urandom_range(0, 1) == 0) ? M_XRD : M_XWR;
      a_typ[i]  = ($urandom_range(0, 1) == 0) ? MT_D : 3'($urandom);
      a_data[i] = {$urandom, $urandom};
    end
  endtask

  initial begin
    logic [N-1:0] v;
    logic rdy, rv;
    logic [TW-1:0] rtag;

    randomize_fields();
    do_reset();

    // Idle after reset.
    step(2'b00, 1'b1, 1'b0, '0);
    check("idle_mvalid", obs_mvalid, 1'b0);
    check("idle_busy", obs_busy, 1'b0);

    // Single requester round trip.
    a_addr[0] = 40'h100;
    a_tag[0] = 8'h05;
    step(2'b01, 1'b1, 1'b0, '0);
    check("single_tag", obs_tag, 10'h005);
    step(2'b00, 1'b1, 1'b1, 10'h005);
    check("single_rv", obs_rv, 2'b01);
    check("single_rtag", obs_rtag, 8'h05);

    // Round robin, then a stalled port must not rotate priority.
    do_reset();
    randomize_fields();
    for (int c = 0; c < 4; c++) begin
      step(2'b11, 1'b1, 1'b0, '0);
      check("rr_grant", obs_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
    end
    for (int c = 0; c < 2; c++) begin
      step(2'b11, 1'b0, 1'b0, '0);
      check("stall_idx", obs_tag[TW-1 -: IW], 2'd0);
    end
    step(2'b11, 1'b1, 1'b0, '0);
    check("stall_hold", obs_ready, 2'b01);

    // Credit exhaustion for requester 1.
    do_reset();
    randomize_fields();
    for (int c = 0; c < MAXO; c++) step(2'b10, 1'b1, 1'b0, '0);
    step(2'b11, 1'b1, 1'b0, '0);
    check("credit_block", obs_ready, 2'b01);
    step(2'b11, 1'b1, 1'b1, {2'd1, a_tag[1]});
    check("credit_rv", obs_rv, 2'b10);
    step(2'b11, 1'b1, 1'b0, '0);
    check("credit_return", obs_ready, 2'b10);

    // Fire and response on requester 0 in the same cycle leave its count unchanged.
    do_reset();
    randomize_fields();
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b1, 10'h011);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b0, '0);
    step(2'b01, 1'b1, 1'b0, '0);
    check("same_cycle_full", obs_ready, 2'b00);
    check("same_cycle_mvalid", obs_mvalid, 1'b0);

    // Random traffic with legal responses only.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      randomize_fields();
      v = N'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      rv = (pend.size() > 0) && ($urandom_range(0, 2) == 0);
      rtag = rv ? pend[$urandom_range(0, pend.size() - 1)] : TW'($urandom);
      step(v, rdy, rv, rtag);
    end

    // Protocol errors: out-of-range index, then response with no credit.
    do_reset();
    step(2'b00, 1'b1, 1'b1, 10'h2AA);
    check("bad_idx_rv", obs_rv, 2'b00);
    step(2'b00, 1'b0, 1'b0, '0);
    check("bad_idx_err", obs_err, 1'b1);
    do_reset();
    step(2'b00, 1'b1, 1'b1, 10'h033);
    check("nocredit_rv", obs_rv, 2'b01);
    step(2'b00, 1'b0, 1'b0, '0);
    check("nocredit_err", obs_err, 1'b1);
    do_reset();
    step(2'b00, 1'b0, 1'b0, '0);
    check("err_cleared", obs_err, 1'b0);
    check("end_busy", obs_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
